ws_stream_fifo: RTL

//  Synchronous valid/ready FIFO that buffers WIDTH_S-bit words ahead of the

---
 rtl/ws_stream_fifo.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ws_stream_fifo.sv
// ws_stream_fifo: synchronous valid/ready FIFO with show-ahead output.
// Words are buffered ahead of a WIDTH_S-wide consumer stage. All handshake
// outputs, occupancy and the head word are registered, so nothing on the
// output side depends combinationally on wr_vld or rd_rdy.
// Optional feature: define WS_STREAM_FIFO_PEAK_EN to add the peak occupancy
// tracker (peak_clr / peak_count ports).
module ws_stream_fifo #(
  parameter int WIDTH_S  = 8,
  parameter int DEPTH    = 16,
  parameter int AFULL_TH = 12,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_vld,
  output logic               wr_rdy,
  input  logic [WIDTH_S-1:0] wr_data,
  output logic               rd_vld,
  input  logic               rd_rdy,
  output logic [WIDTH_S-1:0] rd_data,
  output logic [AW:0]        count,
  output logic               afull
`ifdef WS_STREAM_FIFO_PEAK_EN
  ,
  input  logic               peak_clr,
  output logic [AW:0]        peak_count
`endif
);

  localparam logic [AW:0] AFULL_TH_V = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

  logic [WIDTH_S-1:0] mem_r [DEPTH];

  logic [AW:0]        wr_ptr_r;
  logic [AW:0]        rd_ptr_r;
  logic [AW:0]        count_r;
  logic               wr_rdy_r;
  logic               rd_vld_r;
  logic               afull_r;
  logic [WIDTH_S-1:0] rd_data_r;

  logic               wr_en_s;
  logic               rd_en_s;
  logic [AW:0]        wr_ptr_nxt_s;
  logic [AW:0]        rd_ptr_nxt_s;
  logic [AW:0]        count_nxt_s;
  logic               full_nxt_s;
  logic               empty_nxt_s;
  logic [WIDTH_S-1:0] rd_data_nxt_s;

  assign wr_rdy  = wr_rdy_r;
  assign rd_vld  = rd_vld_r;
  assign count   = count_r;
  assign afull   = afull_r;
  assign rd_data = rd_data_r;

  // Transfer qualification and next-state pointers/occupancy.
  always_comb begin
    wr_en_s      = wr_vld && wr_rdy_r;
    rd_en_s      = rd_vld_r && rd_rdy;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (wr_en_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_en_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    full_nxt_s  = (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                  (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
  end

  // Next head word: forward the incoming word when it lands in the slot that
  // becomes the head, otherwise read storage; hold while the FIFO stays empty.
  always_comb begin
    rd_data_nxt_s = rd_data_r;
    if (empty_nxt_s) begin
      rd_data_nxt_s = rd_data_r;
    end else if (wr_en_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
      rd_data_nxt_s = wr_data;
    end else begin
      rd_data_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // Storage array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  // Pointers, occupancy, flags and the registered head word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= '0;
      rd_ptr_r  <= '0;
      count_r   <= '0;
      wr_rdy_r  <= 1'b1;
      rd_vld_r  <= 1'b0;
      afull_r   <= 1'b0;
      rd_data_r <= '0;
    end else begin
      wr_ptr_r  <= wr_ptr_nxt_s;
      rd_ptr_r  <= rd_ptr_nxt_s;
      count_r   <= count_nxt_s;
      wr_rdy_r  <= !full_nxt_s;
      rd_vld_r  <= !empty_nxt_s;
      afull_r   <= (count_nxt_s >= AFULL_TH_V);
      rd_data_r <= rd_data_nxt_s;
    end
  end

`ifdef WS_STREAM_FIFO_PEAK_EN
  logic [AW:0] peak_r;

  assign peak_count = peak_r;

  // Peak occupancy tracker; a clear reloads it with the next occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_r <= '0;
    end else if (peak_clr) begin
      peak_r <= count_nxt_s;
    end else if (count_nxt_s > peak_r) begin
      peak_r <= count_nxt_s;
    end else begin
      peak_r <= peak_r;
    end
  end
`endif

endmodule
